// File: rtl/x1_video_timing.sv
// x1_video_timing: raster timing and test-pattern generator for the SharpX1 core.
// Emits a one-clk pixel enable, H/V blank and sync, pixel counters, a frame
// start pulse and per-channel RGB. Geometry (pal, scandouble, pattern) is
// latched at each frame boundary; tint applies at the next pixel.
// Optional feature macro: X1_VTG_LFSR_EN (16-bit LFSR noise for pattern 3).
// Without it, pattern 3 is solid white in the active area.
module x1_video_timing #(
    parameter int COLOR_W     = 8,
    parameter int CE_DIV      = 4,
    parameter int H_ACTIVE    = 320,
    parameter int H_FP        = 40,
    parameter int H_SYNC      = 48,
    parameter int H_BP        = 104,
    parameter int V_ACTIVE    = 240,
    parameter int V_NTSC_FP   = 3,
    parameter int V_NTSC_SYNC = 3,
    parameter int V_NTSC_BP   = 16,
    parameter int V_PAL_FP    = 27,
    parameter int V_PAL_SYNC  = 3,
    parameter int V_PAL_BP    = 42
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pal,
    input  logic               scandouble,
    input  logic [1:0]         pattern,
    input  logic [2:0]         tint,
    output logic               ce_pix,
    output logic               hblank,
    output logic               hsync,
    output logic               vblank,
    output logic               vsync,
    output logic [9:0]         hcount,
    output logic [9:0]         vcount,
    output logic               frame_start,
    output logic [COLOR_W-1:0] r,
    output logic [COLOR_W-1:0] g,
    output logic [COLOR_W-1:0] b
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_NTSC_TOTAL = V_ACTIVE + V_NTSC_FP + V_NTSC_SYNC + V_NTSC_BP;
    localparam int V_PAL_TOTAL  = V_ACTIVE + V_PAL_FP + V_PAL_SYNC + V_PAL_BP;
    localparam int BAR_W        = H_ACTIVE / 8;
    localparam int DW           = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

    localparam logic [DW-1:0] DIV_FULL = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CE_DIV / 2 - 1);

    // Bounds are 11 bits wide so a 1024-wide raster still compares correctly.
    localparam logic [10:0] H_ACT_L   = 11'(H_ACTIVE);
    localparam logic [10:0] HS_LO     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_HI     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT_L   = 11'(V_ACTIVE);
    localparam logic [10:0] VN_VS_LO  = 11'(V_ACTIVE + V_NTSC_FP);
    localparam logic [10:0] VN_VS_HI  = 11'(V_ACTIVE + V_NTSC_FP + V_NTSC_SYNC);
    localparam logic [10:0] VP_VS_LO  = 11'(V_ACTIVE + V_PAL_FP);
    localparam logic [10:0] VP_VS_HI  = 11'(V_ACTIVE + V_PAL_FP + V_PAL_SYNC);
    localparam logic [9:0]  VN_LAST   = 10'(V_NTSC_TOTAL - 1);
    localparam logic [9:0]  VP_LAST   = 10'(V_PAL_TOTAL - 1);

    // Reject parameter sets the 10-bit counters cannot represent.
    if (H_TOTAL > 1024) begin : g_h_total_err
        $error("x1_video_timing: H_TOTAL exceeds 1024");
    end
    if (V_NTSC_TOTAL > 1024 || V_PAL_TOTAL > 1024) begin : g_v_total_err
        $error("x1_video_timing: V_TOTAL exceeds 1024");
    end
    if (CE_DIV < 2 || (CE_DIV % 2) != 0) begin : g_ce_div_err
        $error("x1_video_timing: CE_DIV must be even and >= 2");
    end

    logic [DW-1:0]      div_q, div_d;
    logic               ce_pix_q, ce_pix_d;
    logic [9:0]         hc_q, hc_d;
    logic [9:0]         vc_q, vc_d;
    logic               rep_q, rep_d;
    logic               pal_q, pal_d;
    logic               sd_q, sd_d;
    logic [1:0]         pat_q, pat_d;
    logic [9:0]         hcount_q, hcount_d;
    logic [9:0]         vcount_q, vcount_d;
    logic               hblank_q, hblank_d;
    logic               hsync_q, hsync_d;
    logic               vblank_q, vblank_d;
    logic               vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d;
    logic [COLOR_W-1:0] r_q, r_d;
    logic [COLOR_W-1:0] g_q, g_d;
    logic [COLOR_W-1:0] b_q, b_d;
`ifdef X1_VTG_LFSR_EN
    logic [15:0]        lfsr_q, lfsr_d;
`endif

    logic               tick;
    logic [10:0]        hc_x, vc_x;
    logic [9:0]         vtot_last;
    logic               hb, hs, vb, vs, active;
    logic [2:0]         bar_k;
    logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

    // Raster decode of the pixel the counters currently point at.
    always_comb begin
        hc_x      = {1'b0, hc_q};
        vc_x      = {1'b0, vc_q};
        vtot_last = pal_q ? VP_LAST : VN_LAST;
        hb        = hc_x >= H_ACT_L;
        hs        = (hc_x >= HS_LO) && (hc_x < HS_HI);
        vb        = vc_x >= V_ACT_L;
        if (pal_q) begin
            vs = (vc_x >= VP_VS_LO) && (vc_x < VP_VS_HI);
        end else begin
            vs = (vc_x >= VN_VS_LO) && (vc_x < VN_VS_HI);
        end
        active = !hb && !vb;
    end

    // Colour-bar index from a ladder of comparators (no divider).
    always_comb begin
        bar_k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hc_x >= 11'(i * BAR_W)) begin
                bar_k = 3'(i);
            end
        end
    end

    // Pattern selection, then blanking and tint gating.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (pat_q)
            2'd0: begin
                pix_r = COLOR_W'(hc_q);
                pix_g = COLOR_W'(hc_q);
                pix_b = COLOR_W'(hc_q);
            end
            2'd1: begin
                pix_g = {COLOR_W{~bar_k[2]}};
                pix_r = {COLOR_W{~bar_k[1]}};
                pix_b = {COLOR_W{~bar_k[0]}};
            end
            2'd2: begin
                pix_r = {COLOR_W{hc_q[3] ^ vc_q[3]}};
                pix_g = {COLOR_W{hc_q[3] ^ vc_q[3]}};
                pix_b = {COLOR_W{hc_q[3] ^ vc_q[3]}};
            end
            default: begin
`ifdef X1_VTG_LFSR_EN
                pix_r = COLOR_W'(lfsr_q);
                pix_g = COLOR_W'(lfsr_q);
                pix_b = COLOR_W'(lfsr_q);
`else
                pix_r = '1;
                pix_g = '1;
                pix_b = '1;
`endif
            end
        endcase
        if (!active || !tint[2]) pix_r = '0;
        if (!active || !tint[1]) pix_g = '0;
        if (!active || !tint[0]) pix_b = '0;
    end

    // Divider, counter advance, frame-boundary relatch and output capture.
    always_comb begin
        div_d         = div_q + 1'b1;
        ce_pix_d      = 1'b0;
        hc_d          = hc_q;
        vc_d          = vc_q;
        rep_d         = rep_q;
        pal_d         = pal_q;
        sd_d          = sd_q;
        pat_d         = pat_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hblank_d      = hblank_q;
        hsync_d       = hsync_q;
        vblank_d      = vblank_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_start_q;
        r_d           = r_q;
        g_d           = g_q;
        b_d           = b_q;
`ifdef X1_VTG_LFSR_EN
        lfsr_d        = lfsr_q;
`endif
        tick          = (div_q == (sd_q ? DIV_HALF : DIV_FULL));

        if (tick) begin
            div_d         = '0;
            ce_pix_d      = 1'b1;
            hcount_d      = hc_q;
            vcount_d      = vc_q;
            hblank_d      = hb;
            hsync_d       = hs;
            vblank_d      = vb;
            vsync_d       = vs;
            frame_start_d = (hc_q == 10'd0) && (vc_q == 10'd0) && !rep_q;
            r_d           = pix_r;
            g_d           = pix_g;
            b_d           = pix_b;
`ifdef X1_VTG_LFSR_EN
            if (active) begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            end
`endif
            if (hc_q == H_LAST) begin
                hc_d = 10'd0;
                if (sd_q && !rep_q) begin
                    // Scandoubled: replay the same source line once more.
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    if (vc_q == vtot_last) begin
                        // Frame boundary: next frame's geometry is fixed here.
                        vc_d  = 10'd0;
                        pal_d = pal;
                        sd_d  = scandouble;
                        pat_d = pattern;
                    end else begin
                        vc_d = vc_q + 10'd1;
                    end
                end
            end else begin
                hc_d = hc_q + 10'd1;
            end
        end
    end

    // State register; mode registers track their inputs while in reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q         <= '0;
            ce_pix_q      <= 1'b0;
            hc_q          <= 10'd0;
            vc_q          <= 10'd0;
            rep_q         <= 1'b0;
            pal_q         <= pal;
            sd_q          <= scandouble;
            pat_q         <= pattern;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            hblank_q      <= 1'b1;
            hsync_q       <= 1'b0;
            vblank_q      <= 1'b1;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            r_q           <= '0;
            g_q           <= '0;
            b_q           <= '0;
`ifdef X1_VTG_LFSR_EN
            lfsr_q        <= 16'hACE1;
`endif
        end else begin
            div_q         <= div_d;
            ce_pix_q      <= ce_pix_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            rep_q         <= rep_d;
            pal_q         <= pal_d;
            sd_q          <= sd_d;
            pat_q         <= pat_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hblank_q      <= hblank_d;
            hsync_q       <= hsync_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
`ifdef X1_VTG_LFSR_EN
            lfsr_q        <= lfsr_d;
`endif
        end
    end

    assign ce_pix      = ce_pix_q;
    assign hblank      = hblank_q;
    assign hsync       = hsync_q;
    assign vblank      = vblank_q;
    assign vsync       = vsync_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign frame_start = frame_start_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;

endmodule

// File: tb/tb_x1_video_timing.sv
// Bench for x1_video_timing on a reduced raster (48 x 24 NTSC / 48 x 28 PAL)
// so several whole frames fit in a short run. The reference model locates
// each pixel from its index within the frame using plain division.
module tb_x1_video_timing;
    localparam int CW     = 8;
    localparam int CE_DIV = 4;
    localparam int HA = 32, HFP = 4, HSW = 4, HBP = 8;
    localparam int VA = 16;
    localparam int VN_FP = 2, VN_SY = 2, VN_BP = 4;
    localparam int VP_FP = 3, VP_SY = 2, VP_BP = 7;
    localparam int HT   = HA + HFP + HSW + HBP;
    localparam int VT_N = VA + VN_FP + VN_SY + VN_BP;
    localparam int VT_P = VA + VP_FP + VP_SY + VP_BP;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pal, scandouble;
    logic [1:0]    pattern;
    logic [2:0]    tint;
    logic          ce_pix, hblank, hsync, vblank, vsync, frame_start;
    logic [9:0]    hcount, vcount;
    logic [CW-1:0] r, g, b;

    int checks = 0;
    int errors = 0;

    // Reference model state: pixel index within frame and the frame's mode.
    int          m_n;
    bit          m_pal, m_sd;
    int          m_pat;
    logic [15:0] m_lfsr;

    x1_video_timing #(
        .COLOR_W(CW), .CE_DIV(CE_DIV),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA),
        .V_NTSC_FP(VN_FP), .V_NTSC_SYNC(VN_SY), .V_NTSC_BP(VN_BP),
        .V_PAL_FP(VP_FP), .V_PAL_SYNC(VP_SY), .V_PAL_BP(VP_BP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble),
        .pattern(pattern), .tint(tint), .ce_pix(ce_pix), .hblank(hblank),
        .hsync(hsync), .vblank(vblank), .vsync(vsync), .hcount(hcount),
        .vcount(vcount), .frame_start(frame_start), .r(r), .g(g), .b(b)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (pixel %0d)", tag, obs, exp, m_n);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_ce_pix", 32'(ce_pix), 0);
        chk("rst_hblank", 32'(hblank), 1);
        chk("rst_vblank", 32'(vblank), 1);
        chk("rst_hsync", 32'(hsync), 0);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_hcount", 32'(hcount), 0);
        chk("rst_vcount", 32'(vcount), 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_rgb", {8'h0, r, g, b}, 0);
    endtask

    task automatic reset_model();
        m_n    = 0;
        m_pal  = pal;
        m_sd   = scandouble;
        m_pat  = int'(pattern);
        m_lfsr = 16'hACE1;
    endtask

    function automatic int frame_len();
        return HT * (m_pal ? VT_P : VT_N) * (m_sd ? 2 : 1);
    endfunction

    // Wait for the next pixel enable, then compare the whole pixel against the model.
    task automatic step();
        bit          in_pal = pal;
        bit          in_sd  = scandouble;
        int          in_pat = int'(pattern);
        logic [2:0]  in_tint = tint;
        int          cnt = 0;
        int          per = m_sd ? CE_DIV / 2 : CE_DIV;
        int          ln, h, v, k, vfp, vsy;
        bit          e_hb, e_hs, e_vb, e_vs, act;
        logic [7:0]  er, eg, eb;

        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (!ce_pix && cnt < 4 * CE_DIV);
        chk("ce_period", cnt, per);

        ln   = m_n / HT;
        h    = m_n % HT;
        v    = m_sd ? ln / 2 : ln;
        vfp  = m_pal ? VP_FP : VN_FP;
        vsy  = m_pal ? VP_SY : VN_SY;
        e_hb = h >= HA;
        e_hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
        e_vb = v >= VA;
        e_vs = (v >= VA + vfp) && (v < VA + vfp + vsy);
        act  = !e_hb && !e_vb;

        case (m_pat)
            0: begin er = 8'(h); eg = 8'(h); eb = 8'(h); end
            1: begin
                k  = h / (HA / 8);
                eg = (k & 4) ? 8'h00 : 8'hFF;
                er = (k & 2) ? 8'h00 : 8'hFF;
                eb = (k & 1) ? 8'h00 : 8'hFF;
            end
            2: begin
                er = (((h >> 3) ^ (v >> 3)) & 1) ? 8'hFF : 8'h00;
                eg = er;
                eb = er;
            end
            default: begin
`ifdef X1_VTG_LFSR_EN
                er = m_lfsr[7:0];
`else
                er = 8'hFF;
`endif
                eg = er;
                eb = er;
            end
        endcase
        if (!act || !in_tint[2]) er = 8'h00;
        if (!act || !in_tint[1]) eg = 8'h00;
        if (!act || !in_tint[0]) eb = 8'h00;

        chk("hcount", 32'(hcount), h);
        chk("vcount", 32'(vcount), v);
        chk("hblank", 32'(hblank), 32'(e_hb));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vblank", 32'(vblank), 32'(e_vb));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("frame_start", 32'(frame_start), (m_n == 0) ? 1 : 0);
        chk("rgb", {8'h0, r, g, b}, {8'h0, er, eg, eb});

`ifdef X1_VTG_LFSR_EN
        if (act) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        if (m_n == frame_len() - 1) begin
            m_n   = 0;
            m_pal = in_pal;
            m_sd  = in_sd;
            m_pat = in_pat;
        end else begin
            m_n++;
        end
    endtask

    task automatic jiggle_tint();
        if ($urandom_range(0, 31) == 0) begin
            tint = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
        end
    endtask

    // Directed sequence with randomized tint and mode-change points.
    initial begin
        int chg;
        reset_n    = 1'b0;
        pal        = 1'b0;
        scandouble = 1'b0;
        pattern    = 2'd0;
        tint       = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset_model();
        reset_n = 1'b1;

        // Frame A: NTSC gradient; request PAL + checkerboard mid-frame.
        chg = $urandom_range(100, 900);
        for (int i = 0; i < HT * VT_N; i++) begin
            if (i == chg) begin pal = 1'b1; pattern = 2'd2; end
            jiggle_tint();
            step();
        end

        // Frame B: PAL checkerboard; request NTSC scandoubled bars mid-frame.
        chg = $urandom_range(100, 1200);
        for (int i = 0; i < HT * VT_P; i++) begin
            if (i == chg) begin pal = 1'b0; scandouble = 1'b1; pattern = 2'd1; end
            jiggle_tint();
            step();
        end

        // Frame C: scandoubled NTSC colour bars; request pattern 3 normal rate.
        chg = $urandom_range(100, 2000);
        for (int i = 0; i < 2 * HT * VT_N; i++) begin
            if (i == chg) begin scandouble = 1'b0; pattern = 2'd3; end
            jiggle_tint();
            step();
        end

        // Frame D: pattern 3, partial frame, then a one-clock mid-line reset.
        tint = 3'b111;
        for (int i = 0; i < 600; i++) begin
            step();
        end
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset_model();
        reset_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            jiggle_tint();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
